// File: rtl/adder_tree_diff_node_if.sv
// adder_tree_diff_node_if: input (a/b) and output (out/out_ovf) valid/ready channels
// of one difference node. The node takes the slave side; the producer/consumer the master side.
interface adder_tree_diff_node_if #(
    parameter int IN_BITS  = 16,
    parameter int OUT_BITS = 17
);
    logic                in_valid;
    logic                in_ready;
    logic [IN_BITS-1:0]  a;
    logic [IN_BITS-1:0]  b;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] out;
    logic                out_ovf;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, out_ovf
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, out_ovf
    );
endinterface

// File: rtl/adder_tree_diff_node.sv
// adder_tree_diff_node: pipelined out = ext(a) - (ext(b) << B_SHIFT) with valid/ready
// handshake and an out-of-range flag.
// Build option: ADDER_TREE_DIFF_SAT_EN clamps overflowed results instead of wrapping;
// it only touches the output-stage data, latency and handshake are unchanged.
module adder_tree_diff_node #(
    parameter int IN_BITS         = 16,
    parameter int OUT_BITS        = 17,
    parameter int SIGN_EXT        = 1,
    parameter int B_SHIFT         = 1,
    parameter int REGISTER_MIDDLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    adder_tree_diff_node_if.slave  bus
);
    // One guard bit above OUT_BITS holds the true sign / borrow of the difference.
    localparam int W    = OUT_BITS + 1;
    localparam int LS_W = OUT_BITS / 2;
    localparam int MS_W = W - LS_W;

    // Half-finished subtraction handed from the low-half stage to the output stage.
    typedef struct packed {
        logic [LS_W-1:0] ls;
        logic            borrow;
        logic [MS_W-1:0] a_ms;
        logic [MS_W-1:0] b_ms;
    } split_t;

    logic [W-1:0]        a_ext;
    logic [W-1:0]        b_ext;
    logic [W-1:0]        b_sh;
    logic [LS_W:0]       ls_diff;
    split_t              split_in;
    split_t              s1;
    logic                s1_valid;
    logic                out_free;
    logic [MS_W-1:0]     ms_diff;
    logic [W-1:0]        diff;
    logic                ovf;
    logic [OUT_BITS-1:0] res;

    // Extend both operands, shift b, and subtract the low LS_W bits keeping the borrow.
    always_comb begin
        if (SIGN_EXT != 0) begin
            a_ext = {{(W-IN_BITS){bus.a[IN_BITS-1]}}, bus.a};
            b_ext = {{(W-IN_BITS){bus.b[IN_BITS-1]}}, bus.b};
        end else begin
            a_ext = {{(W-IN_BITS){1'b0}}, bus.a};
            b_ext = {{(W-IN_BITS){1'b0}}, bus.b};
        end
        b_sh            = b_ext << B_SHIFT;
        ls_diff         = {1'b0, a_ext[LS_W-1:0]} - {1'b0, b_sh[LS_W-1:0]};
        split_in.ls     = ls_diff[LS_W-1:0];
        split_in.borrow = ls_diff[LS_W];
        split_in.a_ms   = a_ext[W-1:LS_W];
        split_in.b_ms   = b_sh[W-1:LS_W];
    end

    // The output register can take a new entry when empty or when its entry leaves now.
    assign out_free = !bus.out_valid || bus.out_ready;

    generate
        if (REGISTER_MIDDLE != 0) begin : g_mid
            // Middle register: loads when empty or when its entry moves to the output stage.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                end else if (!s1_valid || out_free) begin
                    s1_valid <= bus.in_valid;
                    if (bus.in_valid) begin
                        s1 <= split_in;
                    end
                end
            end

            // Combinational in out_ready so a streaming pipe never inserts bubbles.
            assign bus.in_ready = !s1_valid || out_free;
        end else begin : g_flat
            assign s1_valid     = bus.in_valid;
            assign s1           = split_in;
            assign bus.in_ready = out_free;
        end
    endgenerate

    // Finish the high half with the carried borrow, flag overflow and form the result.
    always_comb begin
        ms_diff = s1.a_ms - s1.b_ms - {{(MS_W-1){1'b0}}, s1.borrow};
        diff    = {ms_diff, s1.ls};
        if (SIGN_EXT != 0) begin
            ovf = diff[W-1] ^ diff[W-2];
        end else begin
            ovf = diff[W-1];
        end
        res = diff[OUT_BITS-1:0];
`ifdef ADDER_TREE_DIFF_SAT_EN
        if (ovf) begin
            if (SIGN_EXT != 0) begin
                // diff[W-1] is the sign of the exact difference.
                res = diff[W-1] ? {1'b1, {(OUT_BITS-1){1'b0}}}
                                : {1'b0, {(OUT_BITS-1){1'b1}}};
            end else begin
                res = '0;
            end
        end
`endif
    end

    // Output register: holds out/out_ovf stable while stalled, drains to empty otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.out_ovf   <= 1'b0;
        end else if (out_free) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out     <= res;
                bus.out_ovf <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_adder_tree_diff_node.sv
// tb_adder_tree_diff_node: directed table plus handshake corner sequences for three
// node builds (signed 2-stage, unsigned 2-stage, signed 1-stage).
module tb_adder_tree_diff_node;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_tree_diff_node_if #(.IN_BITS(16), .OUT_BITS(17)) if_s ();
    adder_tree_diff_node_if #(.IN_BITS(16), .OUT_BITS(17)) if_u ();
    adder_tree_diff_node_if #(.IN_BITS(16), .OUT_BITS(17)) if_0 ();

    adder_tree_diff_node #(.IN_BITS(16), .OUT_BITS(17), .SIGN_EXT(1), .B_SHIFT(1), .REGISTER_MIDDLE(1))
        u_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
    adder_tree_diff_node #(.IN_BITS(16), .OUT_BITS(17), .SIGN_EXT(0), .B_SHIFT(1), .REGISTER_MIDDLE(1))
        u_u (.clk(clk), .rst_n(rst_n), .bus(if_u));
    adder_tree_diff_node #(.IN_BITS(16), .OUT_BITS(17), .SIGN_EXT(1), .B_SHIFT(1), .REGISTER_MIDDLE(0))
        u_0 (.clk(clk), .rst_n(rst_n), .bus(if_0));

    typedef struct {
        logic [16:0] out;
        logic        ovf;
        int          cyc;
    } res_t;

    typedef struct {
        logic [16:0] o;
        logic        v;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] es;
        logic        os;
        logic [16:0] eu;
        logic        ou;
    } vec_t;

    res_t q_s[$];
    res_t q_u[$];
    res_t q_0[$];
    exp_t es_q[$];
    exp_t eu_q[$];
    vec_t vt[9];

    int n_tests = 0;
    int n_fail  = 0;

    // Record every completed output transfer with the cycle it happened in.
    always @(negedge clk) begin
        if (rst_n && if_s.out_valid && if_s.out_ready) q_s.push_back('{if_s.out, if_s.out_ovf, cyc});
        if (rst_n && if_u.out_valid && if_u.out_ready) q_u.push_back('{if_u.out, if_u.out_ovf, cyc});
        if (rst_n && if_0.out_valid && if_0.out_ready) q_0.push_back('{if_0.out, if_0.out_ovf, cyc});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_all(input logic v, input logic [15:0] a, input logic [15:0] b);
        if_s.in_valid = v; if_s.a = a; if_s.b = b;
        if_u.in_valid = v; if_u.a = a; if_u.b = b;
        if_0.in_valid = v; if_0.a = a; if_0.b = b;
    endtask

    task automatic set_ready(input logic r);
        if_s.out_ready = r;
        if_u.out_ready = r;
        if_0.out_ready = r;
    endtask

    task automatic clear_q();
        q_s.delete(); q_u.delete(); q_0.delete();
    endtask

    // Arithmetic reference: exact integer difference, then wrap or clamp.
    function automatic void ref_model(input logic [15:0] a, input logic [15:0] b, input bit sgn,
                                      output logic [16:0] o, output logic ovf);
        longint av, bv, d;
        av  = sgn ? longint'($signed(a)) : longint'(a);
        bv  = sgn ? longint'($signed(b)) : longint'(b);
        d   = av - 2 * bv;
        ovf = sgn ? (d < -65536 || d > 65535) : (d < 0);
        o   = d[16:0];
`ifdef ADDER_TREE_DIFF_SAT_EN
        if (ovf) o = sgn ? ((d < 0) ? 17'h10000 : 17'h0FFFF) : 17'h0;
`endif
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra, rb;
        exp_t        e;
        int          c0, nxt, acc, drop_at;

        // {a, b, signed out, signed ovf, unsigned out, unsigned ovf}
        vt[0] = '{16'd100,  16'd30,   17'd40,     1'b0, 17'd40,     1'b0};
`ifdef ADDER_TREE_DIFF_SAT_EN
        vt[1] = '{16'h8000, 16'h7FFF, 17'h10000,  1'b1, 17'd0,      1'b1};
        vt[2] = '{16'd10,   16'd20,   17'd131042, 1'b0, 17'd0,      1'b1};
        vt[4] = '{16'h7FFF, 16'h8000, 17'h0FFFF,  1'b1, 17'd0,      1'b1};
`else
        vt[1] = '{16'h8000, 16'h7FFF, 17'd32770,  1'b1, 17'd98306,  1'b1};
        vt[2] = '{16'd10,   16'd20,   17'd131042, 1'b0, 17'd131042, 1'b1};
        vt[4] = '{16'h7FFF, 16'h8000, 17'd98303,  1'b1, 17'd98303,  1'b1};
`endif
        vt[3] = '{16'd500,  16'd7,    17'd486,    1'b0, 17'd486,    1'b0};
        vt[5] = '{16'd0,    16'd0,    17'd0,      1'b0, 17'd0,      1'b0};
        vt[6] = '{16'hFFFF, 16'd0,    17'h1FFFF,  1'b0, 17'd65535,  1'b0};
        vt[7] = '{16'h8000, 16'h4000, 17'h10000,  1'b0, 17'd0,      1'b0};
        vt[8] = '{16'hFFFF, 16'h7FFF, 17'h10001,  1'b0, 17'd1,      1'b0};

        // Reset state
        drive_all(1'b0, 16'd0, 16'd0);
        set_ready(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.s.out_valid", 32'(if_s.out_valid), 0);
        chk("rst.s.out",       32'(if_s.out), 0);
        chk("rst.s.out_ovf",   32'(if_s.out_ovf), 0);
        chk("rst.u.out_valid", 32'(if_u.out_valid), 0);
        chk("rst.0.out_valid", 32'(if_0.out_valid), 0);
        chk("rst.0.out",       32'(if_0.out), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst.s.in_ready", 32'(if_s.in_ready), 1);
        chk("rst.0.in_ready", 32'(if_0.in_ready), 1);

        // Latency: 2 cycles for the split build, 1 for the flat build, valid for one cycle
        @(posedge clk); #1;
        drive_all(1'b1, 16'd100, 16'd30);
        @(posedge clk); #1;
        drive_all(1'b0, 16'd0, 16'd0);
        @(negedge clk);
        chk("lat.s.e1.valid", 32'(if_s.out_valid), 0);
        chk("lat.0.e1.valid", 32'(if_0.out_valid), 1);
        chk("lat.0.e1.out",   32'(if_0.out), 40);
        @(negedge clk);
        chk("lat.s.e2.valid", 32'(if_s.out_valid), 1);
        chk("lat.s.e2.out",   32'(if_s.out), 40);
        chk("lat.s.e2.ovf",   32'(if_s.out_ovf), 0);
        chk("lat.0.e2.valid", 32'(if_0.out_valid), 0);
        @(negedge clk);
        chk("lat.s.e3.valid", 32'(if_s.out_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        clear_q();

        // Directed table
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            drive_all(1'b1, vt[i].a, vt[i].b);
            @(posedge clk); #1;
            drive_all(1'b0, 16'd0, 16'd0);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("vec%0d.s.cnt", i), q_s.size(), 1);
            chk($sformatf("vec%0d.u.cnt", i), q_u.size(), 1);
            chk($sformatf("vec%0d.0.cnt", i), q_0.size(), 1);
            if (q_s.size() > 0) begin
                chk($sformatf("vec%0d.s.out", i), 32'(q_s[0].out), 32'(vt[i].es));
                chk($sformatf("vec%0d.s.ovf", i), 32'(q_s[0].ovf), 32'(vt[i].os));
            end
            if (q_u.size() > 0) begin
                chk($sformatf("vec%0d.u.out", i), 32'(q_u[0].out), 32'(vt[i].eu));
                chk($sformatf("vec%0d.u.ovf", i), 32'(q_u[0].ovf), 32'(vt[i].ou));
            end
            if (q_0.size() > 0) begin
                chk($sformatf("vec%0d.0.out", i), 32'(q_0[0].out), 32'(vt[i].es));
                chk($sformatf("vec%0d.0.ovf", i), 32'(q_0[0].ovf), 32'(vt[i].os));
            end
            clear_q();
        end

        // Backpressure: a=1..8, b=0, out_ready low for the first 5 cycles
        nxt = 1; acc = 0; drop_at = -1;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            set_ready(c >= 5);
            drive_all(nxt <= 8, 16'(nxt), 16'd0);
            @(negedge clk);
            if (if_s.in_valid && if_s.in_ready) begin
                nxt++;
                acc++;
            end else if (if_s.in_valid && !if_s.in_ready && drop_at < 0) begin
                drop_at = acc;
            end
            if (if_s.out_valid && !if_s.out_ready) begin
                chk("stall.hold.out", 32'(if_s.out), 1);
                chk("stall.hold.ovf", 32'(if_s.out_ovf), 0);
            end
            if (nxt > 8 && q_s.size() >= 8) break;
        end
        @(posedge clk); #1;
        drive_all(1'b0, 16'd0, 16'd0);
        set_ready(1'b1);
        chk("stall.accepts_before_drop", drop_at, 2);
        chk("stall.count", q_s.size(), 8);
        for (int k = 0; k < 8 && k < q_s.size(); k++)
            chk($sformatf("stall.order%0d", k), 32'(q_s[k].out), k + 1);
        repeat (6) @(posedge clk);
        #1;
        clear_q();

        // Full-throughput stream of 32 random pairs against the reference model
        es_q.delete(); eu_q.delete();
        acc = 0;
        c0 = cyc;
        for (int i = 0; i < 32; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            drive_all(1'b1, ra, rb);
            ref_model(ra, rb, 1'b1, e.o, e.v); es_q.push_back(e);
            ref_model(ra, rb, 1'b0, e.o, e.v); eu_q.push_back(e);
            #1;
            if (!(if_s.in_ready && if_u.in_ready && if_0.in_ready)) acc++;
            @(posedge clk); #1;
        end
        drive_all(1'b0, 16'd0, 16'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("stream.in_ready_drops", acc, 0);
        chk("stream.s.count", q_s.size(), 32);
        chk("stream.u.count", q_u.size(), 32);
        chk("stream.0.count", q_0.size(), 32);
        for (int k = 0; k < 32; k++) begin
            if (k < q_s.size()) begin
                chk($sformatf("stream.s%0d.out", k), 32'(q_s[k].out), 32'(es_q[k].o));
                chk($sformatf("stream.s%0d.ovf", k), 32'(q_s[k].ovf), 32'(es_q[k].v));
                chk($sformatf("stream.s%0d.cyc", k), q_s[k].cyc, c0 + 2 + k);
            end
            if (k < q_u.size()) begin
                chk($sformatf("stream.u%0d.out", k), 32'(q_u[k].out), 32'(eu_q[k].o));
                chk($sformatf("stream.u%0d.ovf", k), 32'(q_u[k].ovf), 32'(eu_q[k].v));
            end
            if (k < q_0.size()) begin
                chk($sformatf("stream.0_%0d.out", k), 32'(q_0[k].out), 32'(es_q[k].o));
                chk($sformatf("stream.0_%0d.cyc", k), q_0[k].cyc, c0 + 1 + k);
            end
        end
        clear_q();

        // Mid-stream reset with two tokens held in the split pipe
        set_ready(1'b0);
        drive_all(1'b1, 16'd5, 16'd1);
        @(posedge clk); #1;
        drive_all(1'b1, 16'd9, 16'd1);
        @(posedge clk); #1;
        drive_all(1'b0, 16'd0, 16'd0);
        @(negedge clk);
        chk("rstmid.pre.valid", 32'(if_s.out_valid), 1);
        chk("rstmid.pre.out",   32'(if_s.out), 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid.s.valid", 32'(if_s.out_valid), 0);
        chk("rstmid.s.out",   32'(if_s.out), 0);
        chk("rstmid.0.valid", 32'(if_0.out_valid), 0);
        @(posedge clk); #1;
        set_ready(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid.s.stale", q_s.size(), 0);
        chk("rstmid.0.stale", q_0.size(), 0);
        drive_all(1'b1, 16'd77, 16'd3);
        @(posedge clk); #1;
        drive_all(1'b0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid.new.s.count", q_s.size(), 1);
        chk("rstmid.new.0.count", q_0.size(), 1);
        if (q_s.size() > 0) chk("rstmid.new.s.out", 32'(q_s[0].out), 71);
        if (q_0.size() > 0) chk("rstmid.new.0.out", 32'(q_0[0].out), 71);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
